// File: rtl/i2c_shift_engine.sv
// Bidirectional shift register for the I2C datapath: parallel load for TX, serial fill for RX.
// A frame is DATA_WIDTH accepted shift strobes; done pulses for one cycle when the frame completes.
module i2c_shift_engine #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter bit                    MSB_FIRST   = 1'b1,
  localparam int                   CNT_W       = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  par_load,
  input  logic [DATA_WIDTH-1:0] par_in,
  input  logic                  start,
  input  logic                  shift_en,
  input  logic                  ser_in,
  output logic                  ser_out,
  output logic [DATA_WIDTH-1:0] par_out,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(DATA_WIDTH);

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   shreg, shreg_next;
  logic [CNT_W-1:0]        cnt_next;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= RESET_VALUE;
      bit_cnt <= '0;
    end else begin
      shreg   <= shreg_next;
      bit_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = bit_cnt;
    if (clear) begin
      state_next = ST_IDLE;
      shreg_next = RESET_VALUE;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (par_load) shreg_next = par_in;
          if (start) begin
            cnt_next   = '0;
            state_next = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Loads and starts are deliberately not decoded here so a frame in flight stays intact.
          if (shift_en) begin
            shreg_next = MSB_FIRST ? {shreg[DATA_WIDTH-2:0], ser_in}
                                   : {ser_in, shreg[DATA_WIDTH-1:1]};
            cnt_next   = bit_cnt + CNT_W'(1);
            if (cnt_next == FRAME_LEN) state_next = ST_DONE;
          end
        end
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  assign par_out = shreg;
  assign ser_out = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
  assign busy    = (state == ST_SHIFT);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_i2c_shift_engine.sv
// Directed bench for i2c_shift_engine: MSB-first 8-bit, LSB-first 8-bit and 16-bit instances share stimulus.
module tb_i2c_shift_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        par_load = 1'b0;
  logic        start = 1'b0;
  logic        shift_en = 1'b0;
  logic        ser_in = 1'b0;
  logic [7:0]  par_in8 = 8'h00;
  logic [15:0] par_in16 = 16'h0000;

  logic        m_ser, l_ser, w_ser;
  logic [7:0]  m_par, l_par;
  logic [15:0] w_par;
  logic [3:0]  m_cnt, l_cnt;
  logic [4:0]  w_cnt;
  logic        m_busy, l_busy, w_busy;
  logic        m_done, l_done, w_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_shift_engine #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .clear(clear), .par_load(par_load), .par_in(par_in8),
    .start(start), .shift_en(shift_en), .ser_in(ser_in), .ser_out(m_ser),
    .par_out(m_par), .bit_cnt(m_cnt), .busy(m_busy), .done(m_done));

  i2c_shift_engine #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .clear(clear), .par_load(par_load), .par_in(par_in8),
    .start(start), .shift_en(shift_en), .ser_in(ser_in), .ser_out(l_ser),
    .par_out(l_par), .bit_cnt(l_cnt), .busy(l_busy), .done(l_done));

  i2c_shift_engine #(.DATA_WIDTH(16), .RESET_VALUE(16'hFFFF), .MSB_FIRST(1'b1)) dut_w16 (
    .clk(clk), .rst(rst), .clear(clear), .par_load(par_load), .par_in(par_in16),
    .start(start), .shift_en(shift_en), .ser_in(ser_in), .ser_out(w_ser),
    .par_out(w_par), .bit_cnt(w_cnt), .busy(w_busy), .done(w_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (m_par !== 8'h00) begin errors++; $display("FAIL reset_par: got %h expected 00", m_par); end
    checks++; if (m_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", m_cnt); end
    checks++; if (m_busy !== 1'b0 || m_done !== 1'b0) begin errors++; $display("FAIL reset_flags: busy %b done %b expected 0 0", m_busy, m_done); end
    checks++; if (w_par !== 16'hFFFF) begin errors++; $display("FAIL reset_par16: got %h expected ffff", w_par); end
  endtask

  task automatic test_tx();
    logic [7:0] exp_bits;
    int dcount;
    exp_bits = 8'b1010_0101;
    dcount = 0;
    par_in8 = 8'hA5; par_load = 1'b1; start = 1'b1;
    tick();
    par_load = 1'b0; start = 1'b0;
    checks++; if (m_par !== 8'hA5 || m_busy !== 1'b1) begin errors++; $display("FAIL tx_load: par %h busy %b expected a5 1", m_par, m_busy); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (m_ser !== exp_bits[7-i]) begin errors++; $display("FAIL tx_ser_out bit %0d: got %b expected %b", i, m_ser, exp_bits[7-i]); end
      shift_en = 1'b1; ser_in = 1'b0;
      tick();
      shift_en = 1'b0;
      if (m_done === 1'b1) dcount++;
    end
    checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL tx_done_timing: got %b expected 1", m_done); end
    tick();
    if (m_done === 1'b1) dcount++;
    checks++; if (dcount != 1) begin errors++; $display("FAIL tx_done_pulses: got %0d expected 1", dcount); end
    checks++; if (m_par !== 8'h00 || m_cnt !== 4'd8 || m_busy !== 1'b0) begin errors++; $display("FAIL tx_end: par %h cnt %0d busy %b expected 00 8 0", m_par, m_cnt, m_busy); end
  endtask

  task automatic test_rx_back_to_back();
    logic [7:0] pat;
    pat = 8'hCA;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (m_cnt !== 4'd0 || m_busy !== 1'b1) begin errors++; $display("FAIL rx_start: cnt %0d busy %b expected 0 1", m_cnt, m_busy); end
    for (int i = 0; i < 8; i++) begin
      shift_en = 1'b1; ser_in = pat[7-i];
      tick();
    end
    shift_en = 1'b0;
    checks++; if (m_par !== 8'hCA || m_cnt !== 4'd8 || m_done !== 1'b1) begin errors++; $display("FAIL rx_result: par %h cnt %0d done %b expected ca 8 1", m_par, m_cnt, m_done); end
    tick();
    checks++; if (m_done !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL rx_after: done %b busy %b expected 0 0", m_done, m_busy); end
  endtask

  task automatic test_lsb_first();
    par_in8 = 8'h01; par_load = 1'b1; start = 1'b1;
    tick();
    par_load = 1'b0; start = 1'b0;
    checks++; if (l_ser !== 1'b1) begin errors++; $display("FAIL lsb_first_bit: got %b expected 1", l_ser); end
    shift_en = 1'b1; ser_in = 1'b1;
    tick();
    shift_en = 1'b0;
    checks++; if (l_par !== 8'h80) begin errors++; $display("FAIL lsb_shift1: got %h expected 80", l_par); end
    for (int i = 1; i < 8; i++) begin
      shift_en = 1'b1; ser_in = 1'b1;
      tick();
    end
    shift_en = 1'b0;
    checks++; if (l_par !== 8'hFF || l_done !== 1'b1) begin errors++; $display("FAIL lsb_final: par %h done %b expected ff 1", l_par, l_done); end
    tick();
  endtask

  task automatic test_clear();
    logic [7:0] pat;
    pat = 8'h9D;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift_en = 1'b1; ser_in = 1'b1;
      tick();
    end
    shift_en = 1'b0;
    checks++; if (m_cnt !== 4'd3) begin errors++; $display("FAIL clear_pre_cnt: got %0d expected 3", m_cnt); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (m_par !== 8'h00 || m_cnt !== 4'd0 || m_busy !== 1'b0 || m_done !== 1'b0) begin errors++; $display("FAIL clear_state: par %h cnt %0d busy %b done %b expected 00 0 0 0", m_par, m_cnt, m_busy, m_done); end
    tick();
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL clear_no_done: got %b expected 0", m_done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      shift_en = 1'b1; ser_in = pat[7-i];
      tick();
    end
    shift_en = 1'b0;
    checks++; if (m_par !== 8'h9D || m_done !== 1'b1 || m_cnt !== 4'd8) begin errors++; $display("FAIL clear_refill: par %h done %b cnt %0d expected 9d 1 8", m_par, m_done, m_cnt); end
    tick();
  endtask

  task automatic test_ignore();
    start = 1'b1;
    tick();
    start = 1'b0;
    shift_en = 1'b1; ser_in = 1'b1;
    tick();
    ser_in = 1'b0;
    tick();
    shift_en = 1'b0;
    checks++; if (m_par !== 8'h76 || m_cnt !== 4'd2) begin errors++; $display("FAIL ign_pre: par %h cnt %0d expected 76 2", m_par, m_cnt); end
    par_in8 = 8'h3C; par_load = 1'b1; start = 1'b1;
    tick();
    checks++; if (m_par !== 8'h76 || m_cnt !== 4'd2 || m_busy !== 1'b1) begin errors++; $display("FAIL ign_load_start: par %h cnt %0d busy %b expected 76 2 1", m_par, m_cnt, m_busy); end
    shift_en = 1'b1; ser_in = 1'b1;
    tick();
    par_load = 1'b0; start = 1'b0;
    checks++; if (m_par !== 8'hED || m_cnt !== 4'd3) begin errors++; $display("FAIL ign_load_shift: par %h cnt %0d expected ed 3", m_par, m_cnt); end
    ser_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (m_par !== 8'hA0 || m_done !== 1'b1) begin errors++; $display("FAIL ign_frame_end: par %h done %b expected a0 1", m_par, m_done); end
    ser_in = 1'b1; par_load = 1'b1; start = 1'b1;
    tick();
    par_load = 1'b0; start = 1'b0;
    checks++; if (m_par !== 8'hA0 || m_cnt !== 4'd8 || m_busy !== 1'b0) begin errors++; $display("FAIL ign_done_inputs: par %h cnt %0d busy %b expected a0 8 0", m_par, m_cnt, m_busy); end
    tick();
    checks++; if (m_par !== 8'hA0 || m_cnt !== 4'd8 || m_busy !== 1'b0) begin errors++; $display("FAIL ign_idle_shift: par %h cnt %0d busy %b expected a0 8 0", m_par, m_cnt, m_busy); end
    start = 1'b1;
    tick();
    start = 1'b0; shift_en = 1'b0;
    checks++; if (m_par !== 8'hA0 || m_cnt !== 4'd0 || m_busy !== 1'b1) begin errors++; $display("FAIL ign_start_shift: par %h cnt %0d busy %b expected a0 0 1", m_par, m_cnt, m_busy); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_width16();
    logic [15:0] pat;
    pat = 16'h1234;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (w_par !== 16'hFFFF || w_cnt !== 5'd0) begin errors++; $display("FAIL w16_reset: par %h cnt %0d expected ffff 0", w_par, w_cnt); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      shift_en = 1'b1; ser_in = pat[15-i];
      tick();
    end
    checks++; if (w_cnt !== 5'd15 || w_done !== 1'b0 || w_busy !== 1'b1) begin errors++; $display("FAIL w16_pre_last: cnt %0d done %b busy %b expected 15 0 1", w_cnt, w_done, w_busy); end
    ser_in = pat[0];
    tick();
    shift_en = 1'b0;
    checks++; if (w_cnt !== 5'd16 || w_done !== 1'b1 || w_par !== 16'h1234) begin errors++; $display("FAIL w16_final: cnt %0d done %b par %h expected 16 1 1234", w_cnt, w_done, w_par); end
    tick();
    checks++; if (w_done !== 1'b0 || w_cnt !== 5'd16) begin errors++; $display("FAIL w16_after: done %b cnt %0d expected 0 16", w_done, w_cnt); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_back_to_back();
    test_lsb_first();
    test_clear();
    test_ignore();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
